// File: rtl/stage2.sv
`default_nettype none
// ============================================================================
// Module   : stage2
// Purpose  : Execute stage. Holds the ID/EX and EX/MEM registers, the ALU, and
//            a shift-add multiplier that stalls the front end.
// Revision : 1.0
// ============================================================================
module stage2 #(
    parameter int CC_WIDTH = 10,
    parameter int MUL_ITER = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [CC_WIDTH-1:0] Ctrl_code_in,
    input  logic [7:0]          Op_a,
    input  logic [7:0]          Op_b,
    output logic [CC_WIDTH-1:0] Ctrl_code_exec,
    output logic [7:0]          Forward_exec,
    output logic                Stall_req,
    output logic [CC_WIDTH-1:0] Ctrl_code_mem,
    output logic [7:0]          Alu_out,
    output logic [7:0]          Store_data
);

    // Control code layout: {DMEM_WE, OPCODE[3:0], RF_WE, RF_ADDR[2:0], OUTPUT}
    localparam int c_OPC_LSB = CC_WIDTH - 5;
    localparam int c_CNT_W   = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_ITER - 1);

    localparam logic [3:0] c_OP_NOP   = 4'd0;
    localparam logic [3:0] c_OP_ADD   = 4'd1;
    localparam logic [3:0] c_OP_SUB   = 4'd2;
    localparam logic [3:0] c_OP_LOADI = 4'd3;
    localparam logic [3:0] c_OP_INOUT = 4'd4;
    localparam logic [3:0] c_OP_LOAD  = 4'd5;
    localparam logic [3:0] c_OP_STORE = 4'd6;
    localparam logic [3:0] c_OP_JMP   = 4'd7;
    localparam logic [3:0] c_OP_BRZ   = 4'd8;
    localparam logic [3:0] c_OP_BRNZ  = 4'd9;
    localparam logic [3:0] c_OP_AND   = 4'd10;
    localparam logic [3:0] c_OP_OR    = 4'd11;
    localparam logic [3:0] c_OP_XOR   = 4'd12;
    localparam logic [3:0] c_OP_SHL   = 4'd13;
    localparam logic [3:0] c_OP_SHR   = 4'd14;
    localparam logic [3:0] c_OP_MUL   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [CC_WIDTH-1:0] r_ctrl_ex;
    logic [7:0]          r_a;
    logic [7:0]          r_b;
    logic [CC_WIDTH-1:0] r_ctrl_mem;
    logic [7:0]          r_alu_mem;
    logic [7:0]          r_sd_mem;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_mcand;
    logic [7:0]          r_mplier;
    logic [7:0]          r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [7:0]          w_mcand_nxt;
    logic [7:0]          w_mplier_nxt;
    logic [7:0]          w_acc_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic [3:0]          w_op;
    logic                w_is_mul;
    logic [7:0]          w_alu;

    assign w_op     = r_ctrl_ex[c_OPC_LSB +: 4];
    assign w_is_mul = (w_op == c_OP_MUL);

    assign Stall_req      = w_is_mul && (r_state != S_DONE);
    assign Ctrl_code_exec = r_ctrl_ex;
    assign Forward_exec   = w_alu;
    assign Ctrl_code_mem  = r_ctrl_mem;
    assign Alu_out        = r_alu_mem;
    assign Store_data     = r_sd_mem;

    always_comb begin
        w_alu = 8'h00;
        case (w_op)
            c_OP_ADD:   w_alu = r_a + r_b;
            c_OP_SUB:   w_alu = r_a - r_b;
            c_OP_AND:   w_alu = r_a & r_b;
            c_OP_OR:    w_alu = r_a | r_b;
            c_OP_XOR:   w_alu = r_a ^ r_b;
            c_OP_SHL:   w_alu = r_a << r_b[2:0];
            c_OP_SHR:   w_alu = r_a >> r_b[2:0];
            c_OP_LOADI,
            c_OP_INOUT: w_alu = r_a;
            c_OP_LOAD,
            c_OP_STORE: w_alu = r_b;
            // Only meaningful in DONE; the hazard unit ignores it while stalled.
            c_OP_MUL:   w_alu = r_acc;
            c_OP_NOP, c_OP_JMP, c_OP_BRZ, c_OP_BRNZ: w_alu = 8'h00;
            default:    w_alu = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_is_mul) begin
                    w_mcand_nxt  = r_a;
                    w_mplier_nxt = r_b;
                    w_acc_nxt    = 8'h00;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (r_mplier[0]) begin
                    w_acc_nxt = r_acc + r_mcand;
                end
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= 8'h00;
            r_mplier <= 8'h00;
            r_acc    <= 8'h00;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // While stalled, ID/EX holds and EX/MEM takes a bubble so no write repeats.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ctrl_ex  <= '0;
            r_a        <= 8'h00;
            r_b        <= 8'h00;
            r_ctrl_mem <= '0;
            r_alu_mem  <= 8'h00;
            r_sd_mem   <= 8'h00;
        end else if (!Stall_req) begin
            r_ctrl_ex  <= Ctrl_code_in;
            r_a        <= Op_a;
            r_b        <= Op_b;
            r_ctrl_mem <= r_ctrl_ex;
            r_alu_mem  <= w_alu;
            r_sd_mem   <= (w_op == c_OP_STORE) ? r_a : 8'h00;
        end else begin
            r_ctrl_mem <= '0;
            r_alu_mem  <= 8'h00;
            r_sd_mem   <= 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage2.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage2
// Purpose  : Self-checking bench for the execute stage against an arithmetic
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_stage2;

    localparam int CC_WIDTH = 10;
    localparam int MUL_ITER = 8;

    localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,   OP_LOADI = 4'd3;
    localparam logic [3:0] OP_INOUT = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_JMP = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8,  OP_BRNZ = 4'd9, OP_AND = 4'd10,  OP_OR = 4'd11;
    localparam logic [3:0] OP_XOR = 4'd12, OP_SHL = 4'd13, OP_SHR = 4'd14,  OP_MUL = 4'd15;

    logic                Clk = 1'b0;
    logic                Rst = 1'b1;
    logic [CC_WIDTH-1:0] Ctrl_code_in = '0;
    logic [7:0]          Op_a = 8'h00;
    logic [7:0]          Op_b = 8'h00;
    logic [CC_WIDTH-1:0] Ctrl_code_exec;
    logic [7:0]          Forward_exec;
    logic                Stall_req;
    logic [CC_WIDTH-1:0] Ctrl_code_mem;
    logic [7:0]          Alu_out;
    logic [7:0]          Store_data;

    int n_chk = 0;
    int n_err = 0;

    stage2 #(.CC_WIDTH(CC_WIDTH), .MUL_ITER(MUL_ITER)) dut (
        .Clk(Clk), .Rst(Rst), .Ctrl_code_in(Ctrl_code_in), .Op_a(Op_a), .Op_b(Op_b),
        .Ctrl_code_exec(Ctrl_code_exec), .Forward_exec(Forward_exec), .Stall_req(Stall_req),
        .Ctrl_code_mem(Ctrl_code_mem), .Alu_out(Alu_out), .Store_data(Store_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [CC_WIDTH-1:0] mk(input logic dmem, input logic [3:0] op,
                                               input logic rfwe, input logic [2:0] addr,
                                               input logic outp);
        return {dmem, op, rfwe, addr, outp};
    endfunction

    // Reference ALU in plain integer arithmetic.
    function automatic logic [7:0] model_alu(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            OP_ADD:             r = ia + ib;
            OP_SUB:             r = ia - ib + 256;
            OP_AND:             r = int'(a & b);
            OP_OR:              r = int'(a | b);
            OP_XOR:             r = int'(a ^ b);
            OP_SHL:             r = ia * (1 << (ib % 8));
            OP_SHR:             r = ia / (1 << (ib % 8));
            OP_LOADI, OP_INOUT: r = ia;
            OP_LOAD, OP_STORE:  r = ib;
            OP_MUL:             r = ia * ib;
            default:            r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic drive(input logic [CC_WIDTH-1:0] c, input logic [7:0] a, input logic [7:0] b);
        Ctrl_code_in = c;
        Op_a = a;
        Op_b = b;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(CC_WIDTH'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        n_chk++; if (Ctrl_code_exec !== '0) begin n_err++; $display("FAIL reset_exec: got %h want 0", Ctrl_code_exec); end
        n_chk++; if (Ctrl_code_mem !== '0) begin n_err++; $display("FAIL reset_mem: got %h want 0", Ctrl_code_mem); end
        n_chk++; if (Alu_out !== 8'h00) begin n_err++; $display("FAIL reset_alu: got %h want 0", Alu_out); end
        n_chk++; if (Store_data !== 8'h00) begin n_err++; $display("FAIL reset_sd: got %h want 0", Store_data); end
        n_chk++; if (Forward_exec !== 8'h00) begin n_err++; $display("FAIL reset_fwd: got %h want 0", Forward_exec); end
        n_chk++; if (Stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", Stall_req); end
        drive('0, 8'h00, 8'h00);
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_add_wrap();
        logic [CC_WIDTH-1:0] c;
        c = mk(1'b0, OP_ADD, 1'b1, 3'd3, 1'b0);
        drive(c, 8'hF0, 8'h20);
        tick();
        n_chk++; if (Forward_exec !== 8'h10) begin n_err++; $display("FAIL add_fwd: got %h want 10", Forward_exec); end
        n_chk++; if (Ctrl_code_exec !== c) begin n_err++; $display("FAIL add_exec: got %h want %h", Ctrl_code_exec, c); end
        drive('0, 8'h00, 8'h00);
        tick();
        n_chk++; if (Alu_out !== 8'h10) begin n_err++; $display("FAIL add_alu: got %h want 10", Alu_out); end
        n_chk++; if (Ctrl_code_mem[3:1] !== 3'd3 || Ctrl_code_mem !== c) begin
            n_err++; $display("FAIL add_mem: got %h want %h", Ctrl_code_mem, c); end
    endtask

    task automatic test_sub_shl();
        drive(mk(1'b0, OP_SUB, 1'b1, 3'd1, 1'b0), 8'h05, 8'h07);
        tick();
        n_chk++; if (Forward_exec !== 8'hFE) begin n_err++; $display("FAIL sub_fwd: got %h want fe", Forward_exec); end
        drive(mk(1'b0, OP_SHL, 1'b1, 3'd2, 1'b0), 8'h81, 8'h0A);
        tick();
        n_chk++; if (Alu_out !== 8'hFE) begin n_err++; $display("FAIL sub_alu: got %h want fe", Alu_out); end
        n_chk++; if (Forward_exec !== model_alu(OP_SHL, 8'h81, 8'h0A)) begin
            n_err++; $display("FAIL shl_fwd: got %h want %h", Forward_exec, model_alu(OP_SHL, 8'h81, 8'h0A)); end
        drive('0, 8'h00, 8'h00);
        tick();
        n_chk++; if (Alu_out !== 8'h04) begin n_err++; $display("FAIL shl_alu: got %h want 04", Alu_out); end
    endtask

    task automatic test_mul_back_to_back();
        logic [7:0] av [2];
        logic [7:0] bv [2];
        logic [7:0] prev;
        logic [CC_WIDTH-1:0] c;
        int stalls;
        av[0] = 8'h0D; bv[0] = 8'h0B;
        av[1] = 8'hFF; bv[1] = 8'hFF;
        prev = 8'h00;
        for (int k = 0; k < 2; k++) begin
            c = mk(1'b0, OP_MUL, 1'b1, 3'(k + 4), 1'b0);
            drive(c, av[k], bv[k]);
            tick();
            if (k == 1) begin
                n_chk++; if (Alu_out !== prev) begin n_err++; $display("FAIL mul_b2b_alu: got %h want %h", Alu_out, prev); end
            end
            stalls = 0;
            while (Stall_req === 1'b1 && stalls < 30) begin
                stalls++;
                drive(CC_WIDTH'($urandom), 8'($urandom), 8'($urandom));
                tick();
                n_chk++; if (Ctrl_code_mem !== '0 || Alu_out !== 8'h00) begin
                    n_err++; $display("FAIL mul_bubble: got ctrl %h alu %h want 0", Ctrl_code_mem, Alu_out); end
                n_chk++; if (Ctrl_code_exec !== c) begin
                    n_err++; $display("FAIL mul_hold: got %h want %h", Ctrl_code_exec, c); end
            end
            n_chk++; if (stalls != 1 + MUL_ITER) begin n_err++; $display("FAIL mul_stall_len: got %0d want %0d", stalls, 1 + MUL_ITER); end
            prev = model_alu(OP_MUL, av[k], bv[k]);
            n_chk++; if (Forward_exec !== prev) begin n_err++; $display("FAIL mul_fwd: got %h want %h", Forward_exec, prev); end
        end
        drive('0, 8'h00, 8'h00);
        tick();
        n_chk++; if (Alu_out !== 8'h01) begin n_err++; $display("FAIL mul2_alu: got %h want 01", Alu_out); end
        n_chk++; if (Ctrl_code_mem !== c) begin n_err++; $display("FAIL mul2_mem: got %h want %h", Ctrl_code_mem, c); end
    endtask

    task automatic test_reset_mid_mul();
        logic [CC_WIDTH-1:0] c;
        int stalls;
        c = mk(1'b0, OP_MUL, 1'b1, 3'd6, 1'b0);
        drive(c, 8'hA7, 8'h3C);
        tick();
        // capture edge, then one edge into RUN and four more reach cnt = 4
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (Ctrl_code_mem !== '0) begin n_err++; $display("FAIL midrst_mem: got %h want 0", Ctrl_code_mem); end
            tick();
        end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        drive('0, 8'h00, 8'h00);
        n_chk++; if (Stall_req !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b want 0", Stall_req); end
        n_chk++; if (Ctrl_code_mem !== '0 || Ctrl_code_exec !== '0) begin
            n_err++; $display("FAIL midrst_ctrl: got mem %h exec %h want 0", Ctrl_code_mem, Ctrl_code_exec); end
        tick();
        n_chk++; if (Ctrl_code_mem !== '0 || Stall_req !== 1'b0) begin
            n_err++; $display("FAIL midrst_after: got mem %h stall %b want 0", Ctrl_code_mem, Stall_req); end
        drive(c, 8'h07, 8'h09);
        tick();
        stalls = 0;
        while (Stall_req === 1'b1 && stalls < 30) begin
            stalls++;
            tick();
        end
        n_chk++; if (stalls != 1 + MUL_ITER) begin n_err++; $display("FAIL midrst_restart_len: got %0d want %0d", stalls, 1 + MUL_ITER); end
        n_chk++; if (Forward_exec !== 8'h3F) begin n_err++; $display("FAIL midrst_restart_fwd: got %h want 3f", Forward_exec); end
        drive('0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_store_branch();
        logic [CC_WIDTH-1:0] cs, cb;
        cs = mk(1'b1, OP_STORE, 1'b0, 3'd0, 1'b0);
        cb = mk(1'b0, OP_BRZ, 1'b0, 3'd0, 1'b0);
        drive(cs, 8'h55, 8'h20);
        tick();
        drive(cb, 8'h9C, 8'h31);
        tick();
        n_chk++; if (Alu_out !== 8'h20) begin n_err++; $display("FAIL store_addr: got %h want 20", Alu_out); end
        n_chk++; if (Store_data !== 8'h55) begin n_err++; $display("FAIL store_data: got %h want 55", Store_data); end
        n_chk++; if (Ctrl_code_mem[CC_WIDTH-1] !== 1'b1 || Ctrl_code_mem !== cs) begin
            n_err++; $display("FAIL store_mem: got %h want %h", Ctrl_code_mem, cs); end
        drive('0, 8'h00, 8'h00);
        tick();
        n_chk++; if (Alu_out !== 8'h00 || Ctrl_code_mem !== cb) begin
            n_err++; $display("FAIL brz_pass: got alu %h ctrl %h want 00 %h", Alu_out, Ctrl_code_mem, cb); end
    endtask

    task automatic test_random();
        logic [CC_WIDTH-1:0] c, pend_c;
        logic [7:0] a, b, pend_alu, pend_sd, exp_fwd;
        logic [3:0] op;
        int stalls;
        pend_c = '0; pend_alu = 8'h00; pend_sd = 8'h00;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            c  = mk(1'($urandom), op, 1'($urandom), 3'($urandom), 1'($urandom));
            drive(c, a, b);
            tick();
            n_chk++; if (Ctrl_code_mem !== pend_c || Alu_out !== pend_alu || Store_data !== pend_sd) begin
                n_err++; $display("FAIL rand_exmem: got %h/%h/%h want %h/%h/%h",
                                  Ctrl_code_mem, Alu_out, Store_data, pend_c, pend_alu, pend_sd); end
            exp_fwd = model_alu(op, a, b);
            if (op == OP_MUL) begin
                stalls = 0;
                while (Stall_req === 1'b1 && stalls < 30) begin
                    stalls++;
                    drive(CC_WIDTH'($urandom), 8'($urandom), 8'($urandom));
                    tick();
                end
                n_chk++; if (stalls != 1 + MUL_ITER) begin n_err++; $display("FAIL rand_mul_len: got %0d want %0d", stalls, 1 + MUL_ITER); end
                pend_alu = exp_fwd;
                pend_sd  = 8'h00;
                pend_c   = c;
            end else begin
                n_chk++; if (Stall_req !== 1'b0) begin n_err++; $display("FAIL rand_stall: got %b want 0", Stall_req); end
                pend_alu = exp_fwd;
                pend_sd  = (op == OP_STORE) ? a : 8'h00;
                pend_c   = c;
            end
            n_chk++; if (Forward_exec !== exp_fwd) begin
                n_err++; $display("FAIL rand_fwd op %0d: got %h want %h", op, Forward_exec, exp_fwd); end
        end
        drive('0, 8'h00, 8'h00);
        tick();
        n_chk++; if (Ctrl_code_mem !== pend_c || Alu_out !== pend_alu || Store_data !== pend_sd) begin
            n_err++; $display("FAIL rand_last: got %h/%h/%h want %h/%h/%h",
                              Ctrl_code_mem, Alu_out, Store_data, pend_c, pend_alu, pend_sd); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_shl();
        test_mul_back_to_back();
        test_reset_mid_mul();
        test_store_branch();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
